// File: rtl/cpu_duv_bus_model_pkg.sv
// Shared types and constants for the 6502 DUV bus responder.
package cpu_duv_pkg;

    localparam int unsigned MAX_WAIT_STATES = 7;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } bus_state_t;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/cpu_duv_bus_model_if.sv
// CPU-side request/response bus between the DUV and the bus model.
interface cpu_duv_bus_model_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    logic              req;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rdy;

    modport master (output req, rw, addr, wdata, input rdata, rdy);
    modport slave  (input req, rw, addr, wdata, output rdata, rdy);
endinterface

// File: rtl/cpu_duv_bus_model_trace_fifo.sv
// Show-ahead transaction trace FIFO with sticky overflow and synchronous clear.
module cpu_duv_trace_fifo #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     ready,
    input  logic                     clr,
    output logic                     valid,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             pop;
    logic             push_ok;

    assign valid   = (count != '0);
    assign full    = (count == FULL_COUNT);
    assign pop     = valid && ready;
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign head    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;
            if (push && !push_ok) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !rst && !clr) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cpu_duv_bus_model.sv
// Bus responder for the 6502 DUV: RAM with wait states, bench preload port and trace FIFO.
module cpu_duv_bus_model
    import cpu_duv_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned MEM_DEPTH   = 2048,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned TRACE_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    cpu_duv_bus_model_if.slave             cpu,
    input  logic                           ld_en,
    input  logic [ADDR_W-1:0]              ld_addr,
    input  logic [DATA_W-1:0]              ld_data,
    output logic                           tr_valid,
    input  logic                           tr_ready,
    output logic                           tr_rw,
    output logic [ADDR_W-1:0]              tr_addr,
    output logic [DATA_W-1:0]              tr_data,
    output logic [$clog2(TRACE_DEPTH):0]   tr_count,
    output logic                           tr_overflow,
    input  logic                           tr_clr
);
    localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);
    localparam int unsigned TR_W     = 1 + ADDR_W + DATA_W;
    localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    if (!is_pow2(MEM_DEPTH) || !is_pow2(TRACE_DEPTH) || TRACE_DEPTH < 2 ||
        WAIT_STATES > MAX_WAIT_STATES ||
        64'(MEM_DEPTH) > (64'(1) << ADDR_W)) begin : g_bad_params
        $error("cpu_duv_bus_model: illegal parameter combination");
    end

    bus_state_t        state;
    logic [2:0]        wait_cnt;
    logic              lat_rw;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] ram [MEM_DEPTH];

    logic [IDX_W-1:0]  lat_idx;
    logic [IDX_W-1:0]  ld_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_rw;
    logic              entering_resp;
    logic [DATA_W-1:0] ram_rd;
    logic              cpu_write;
    logic              push;
    logic [TR_W-1:0]   push_data;
    logic [TR_W-1:0]   head;
    logic              unused_ld_addr;

    assign lat_idx        = lat_addr[IDX_W-1:0];
    assign ld_idx         = ld_addr[IDX_W-1:0];
    assign unused_ld_addr = ^ld_addr;

    always_comb begin
        entering_resp = 1'b0;
        rd_idx        = lat_idx;
        rd_rw         = lat_rw;
        case (state)
            IDLE: begin
                entering_resp = cpu.req && (WAIT_STATES == 0);
                rd_idx        = cpu.addr[IDX_W-1:0];
                rd_rw         = cpu.rw;
            end
            WAIT:    entering_resp = (wait_cnt == '0);
            default: entering_resp = 1'b0;
        endcase
    end

    // Read data is captured on the edge into RESP, so a preload landing on that
    // same edge is forwarded to give RAM contents as seen during RESP.
    assign ram_rd = (ld_en && ld_idx == rd_idx) ? ld_data : ram[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            lat_rw    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cpu.rdy   <= 1'b0;
            cpu.rdata <= '0;
        end else begin
            cpu.rdy   <= entering_resp;
            cpu.rdata <= (entering_resp && rd_rw) ? ram_rd : '0;
            case (state)
                IDLE: begin
                    if (cpu.req) begin
                        lat_rw    <= cpu.rw;
                        lat_addr  <= cpu.addr;
                        lat_wdata <= cpu.wdata;
                        wait_cnt  <= WAIT_LOAD;
                        state     <= (WAIT_STATES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) state <= RESP;
                    else                wait_cnt <= wait_cnt - 1'b1;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign cpu_write = (state == RESP) && !lat_rw && !rst;

    // Preload is written last so it wins over a same-index CPU write.
    always_ff @(posedge clk) begin
        if (cpu_write) ram[lat_idx] <= lat_wdata;
        if (ld_en)     ram[ld_idx]  <= ld_data;
    end

    assign push      = (state == RESP) && !rst;
    assign push_data = {lat_rw, lat_addr, lat_rw ? cpu.rdata : lat_wdata};

    cpu_duv_trace_fifo #(
        .WIDTH(TR_W),
        .DEPTH(TRACE_DEPTH)
    ) u_trace (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_data),
        .ready    (tr_ready),
        .clr      (tr_clr),
        .valid    (tr_valid),
        .head     (head),
        .count    (tr_count),
        .overflow (tr_overflow)
    );

    assign {tr_rw, tr_addr, tr_data} = head;

endmodule
